// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the memory controller.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
package mem_ctrl_pkg;

    localparam int AddrLen = 32;
    localparam int InstLen = 32;

    // Reset level used by the whole core.
    localparam logic ResetEnable = 1'b1;

    // mem_rw encodings.
    localparam logic rw_read  = 1'b0;
    localparam logic rw_write = 1'b1;

    // Access width requested by the MEM stage.
    typedef enum logic [1:0] {
        No_mem_type = 2'd0,
        mem_type_b  = 2'd1,
        mem_type_h  = 2'd2,
        mem_type_w  = 2'd3
    } memw_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        IF_RD  = 3'd1,
        MEM_RD = 3'd2,
        MEM_WR = 3'd3,
        DONE   = 3'd4
    } state_t;

    // Number of bus bytes moved for a given access width.
    function automatic logic [2:0] nbytes(input logic [1:0] t);
        logic [2:0] n;
        case (t)
            mem_type_b: n = 3'd1;
            mem_type_h: n = 3'd2;
            mem_type_w: n = 3'd4;
            default:    n = 3'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Arbitrates icache fetches and MEM-stage loads/stores onto a byte-serial RAM bus.
// Latency: request in T -> first address T+1; write done T+N+1, read done T+N+2 (fetch T+6).
// Backpressure: non-preemptive grants; MEM wins ties in IDLE; icache_busy stalls MEM during fetches.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   if_req/if_addr               4-byte fetch request from the icache miss path
//   inst_o/inst_valid            fetched word and its one-cycle done pulse
//   icache_busy                  registered: a fetch owns the bus
//   mem_enable/rw/addr/wdata/type  MEM-stage load/store request (1/2/4 bytes)
//   mem_data/mem_data_enable     zero-extended load data and one-cycle done pulse
//   ram_din/ram_dout/ram_a/ram_wr  8-bit external RAM port (read data one cycle after address)
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = AddrLen,
    parameter int DATA_W = InstLen
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] inst_o,
    output logic              inst_valid,
    output logic              icache_busy,

    input  logic              mem_enable,
    input  logic              mem_rw,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic [1:0]        mem_type,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_data_enable,

    input  logic [7:0]        ram_din,
    output logic [7:0]        ram_dout,
    output logic [ADDR_W-1:0] ram_a,
    output logic              ram_wr
);

    state_t            state;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdat;
    logic [2:0]        acc_n;
    logic              is_fetch;
    logic [2:0]        k;
    logic [DATA_W-1:0] asm_dat;

    logic [2:0]        k_nxt;
    logic [1:0]        lane_prev;
    logic [DATA_W-1:0] asm_nxt;
    logic              mem_valid;
    logic              can_grant_mem;
    logic              can_grant_if;
    logic              grant_mem;
    logic              grant_if;

    assign k_nxt     = k + 3'd1;
    // Byte arriving now belongs to the address driven last cycle (k-1).
    // k==4 wraps to lane 3, which is exactly the last byte of a word.
    assign lane_prev = k[1:0] - 2'd1;
    assign mem_valid = mem_enable && (mem_type != No_mem_type);

    // In DONE the finishing requester is still dropping its request,
    // so only the other side is eligible for a grant.
    always_comb begin
        can_grant_mem = 1'b0;
        can_grant_if  = 1'b0;
        if (state == IDLE) begin
            can_grant_mem = 1'b1;
            can_grant_if  = 1'b1;
        end else if (state == DONE) begin
            can_grant_mem = is_fetch;
            can_grant_if  = !is_fetch;
        end
    end

    assign grant_mem = can_grant_mem && mem_valid;
    assign grant_if  = can_grant_if && if_req && !grant_mem;

    always_comb begin
        asm_nxt = asm_dat;
        asm_nxt[{lane_prev, 3'b000} +: 8] = ram_din;
    end

    always_ff @(posedge clk) begin
        if (rst == ResetEnable) begin
            state           <= IDLE;
            acc_addr        <= '0;
            acc_wdat        <= '0;
            acc_n           <= '0;
            is_fetch        <= 1'b0;
            k               <= '0;
            asm_dat         <= '0;
            inst_o          <= '0;
            inst_valid      <= 1'b0;
            icache_busy     <= 1'b0;
            mem_data        <= '0;
            mem_data_enable <= 1'b0;
            ram_dout        <= '0;
            ram_a           <= '0;
            ram_wr          <= 1'b0;
        end else begin
            // Done pulses are single-cycle by default.
            inst_valid      <= 1'b0;
            mem_data_enable <= 1'b0;

            case (state)
                IDLE, DONE: begin
                    k       <= '0;
                    asm_dat <= '0;
                    if (grant_mem) begin
                        state    <= (mem_rw == rw_write) ? MEM_WR : MEM_RD;
                        acc_addr <= mem_addr;
                        acc_wdat <= mem_wdata;
                        acc_n    <= nbytes(mem_type);
                        is_fetch <= 1'b0;
                        ram_a    <= mem_addr;
                        ram_wr   <= (mem_rw == rw_write);
                        ram_dout <= (mem_rw == rw_write) ? mem_wdata[7:0] : 8'h00;
                    end else if (grant_if) begin
                        state       <= IF_RD;
                        acc_addr    <= if_addr;
                        acc_wdat    <= '0;
                        acc_n       <= 3'd4;
                        is_fetch    <= 1'b1;
                        icache_busy <= 1'b1;
                        ram_a       <= if_addr;
                        ram_wr      <= 1'b0;
                        ram_dout    <= 8'h00;
                    end else begin
                        state    <= IDLE;
                        ram_a    <= '0;
                        ram_wr   <= 1'b0;
                        ram_dout <= 8'h00;
                    end
                end

                MEM_WR: begin
                    if (k == acc_n - 3'd1) begin
                        state           <= DONE;
                        mem_data_enable <= 1'b1;
                        ram_a           <= '0;
                        ram_wr          <= 1'b0;
                        ram_dout        <= 8'h00;
                    end else begin
                        k        <= k_nxt;
                        ram_a    <= acc_addr + ADDR_W'(k_nxt);
                        ram_dout <= acc_wdat[{k_nxt[1:0], 3'b000} +: 8];
                    end
                end

                IF_RD, MEM_RD: begin
                    if (k != 3'd0) begin
                        asm_dat <= asm_nxt;
                    end
                    if (k == acc_n) begin
                        // Last byte captured this cycle: publish and pulse.
                        state       <= DONE;
                        icache_busy <= 1'b0;
                        if (is_fetch) begin
                            inst_o     <= asm_nxt;
                            inst_valid <= 1'b1;
                        end else begin
                            mem_data        <= asm_nxt;
                            mem_data_enable <= 1'b1;
                        end
                    end else begin
                        k <= k_nxt;
                        // After the final address the bus idles for the capture cycle.
                        ram_a <= (k_nxt == acc_n) ? '0 : acc_addr + ADDR_W'(k_nxt);
                    end
                end

                default: begin
                    state       <= IDLE;
                    icache_busy <= 1'b0;
                    ram_a       <= '0;
                    ram_wr      <= 1'b0;
                    ram_dout    <= 8'h00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed testbench for mem_ctrl with a byte-wide RAM model (read data one cycle after address).
// Latency: n/a.
// Backpressure: n/a.
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] inst_o;
    logic        inst_valid;
    logic        icache_busy;
    logic        mem_enable;
    logic        mem_rw;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [1:0]  mem_type;
    logic [31:0] mem_data;
    logic        mem_data_enable;
    logic [7:0]  ram_din = 8'h00;
    logic [7:0]  ram_dout;
    logic [31:0] ram_a;
    logic        ram_wr;

    logic [7:0]  ram [0:1023];

    int total = 0;
    int bad   = 0;

    mem_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .if_req          (if_req),
        .if_addr         (if_addr),
        .inst_o          (inst_o),
        .inst_valid      (inst_valid),
        .icache_busy     (icache_busy),
        .mem_enable      (mem_enable),
        .mem_rw          (mem_rw),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_type        (mem_type),
        .mem_data        (mem_data),
        .mem_data_enable (mem_data_enable),
        .ram_din         (ram_din),
        .ram_dout        (ram_dout),
        .ram_a           (ram_a),
        .ram_wr          (ram_wr)
    );

    always #5 clk = ~clk;

    // Synchronous-read RAM: byte for the address seen at an edge appears in the next cycle.
    always @(posedge clk) ram_din <= ram[ram_a[9:0]];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick(); tick();
        total++;
        if ({inst_o, mem_data} !== 64'h0) begin
            bad++; $display("FAIL reset_data inst_o=%h mem_data=%h want 0/0", inst_o, mem_data);
        end
        total++;
        if ({inst_valid, mem_data_enable, icache_busy, ram_wr} !== 4'b0000) begin
            bad++; $display("FAIL reset_flags iv=%b mde=%b busy=%b wr=%b want 0", inst_valid, mem_data_enable, icache_busy, ram_wr);
        end
        total++;
        if ({ram_a, ram_dout} !== 40'h0) begin
            bad++; $display("FAIL reset_bus ram_a=%h ram_dout=%h want 0/0", ram_a, ram_dout);
        end
        rst = 1'b0;
        tick();
        total++;
        if (ram_a !== 32'h0 || ram_wr !== 1'b0 || icache_busy !== 1'b0) begin
            bad++; $display("FAIL reset_idle ram_a=%h wr=%b busy=%b want 0", ram_a, ram_wr, icache_busy);
        end
    endtask

    // mem_enable with No_mem_type must not start an access.
    task automatic test_no_type();
        mem_enable = 1'b1; mem_rw = 1'b0; mem_type = 2'd0; mem_addr = 32'h100;
        for (int i = 1; i <= 3; i++) begin
            tick();
            total++;
            if (ram_a !== 32'h0 || ram_wr !== 1'b0 || mem_data_enable !== 1'b0) begin
                bad++; $display("FAIL no_type[%0d] ram_a=%h wr=%b mde=%b want 0", i, ram_a, ram_wr, mem_data_enable);
            end
        end
        mem_enable = 1'b0;
        tick();
    endtask

    // LW at 0x100; requester holds mem_enable until the done pulse.
    task automatic test_lw();
        mem_enable = 1'b1; mem_rw = 1'b0; mem_type = 2'd3; mem_addr = 32'h100;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if (ram_a !== 32'h100 + 32'(i) || ram_wr !== 1'b0 || mem_data_enable !== 1'b0) begin
                bad++; $display("FAIL lw_addr[%0d] ram_a=%h wr=%b mde=%b want %h/0/0", i, ram_a, ram_wr, mem_data_enable, 32'h100 + 32'(i));
            end
        end
        tick(); // T+5
        total++;
        if (mem_data_enable !== 1'b0) begin
            bad++; $display("FAIL lw_early mde=%b want 0", mem_data_enable);
        end
        tick(); // T+6
        total++;
        if (mem_data_enable !== 1'b1 || mem_data !== 32'h44332211) begin
            bad++; $display("FAIL lw_done mde=%b mem_data=%h want 1/44332211", mem_data_enable, mem_data);
        end
        mem_enable = 1'b0;
        tick(); // T+7
        total++;
        if (mem_data_enable !== 1'b0 || mem_data !== 32'h44332211 || ram_a !== 32'h0) begin
            bad++; $display("FAIL lw_after mde=%b mem_data=%h ram_a=%h want 0/44332211/0", mem_data_enable, mem_data, ram_a);
        end
    endtask

    task automatic test_sb();
        mem_enable = 1'b1; mem_rw = 1'b1; mem_type = 2'd1; mem_addr = 32'h30; mem_wdata = 32'h123456AB;
        tick(); // T+1
        total++;
        if (ram_wr !== 1'b1 || ram_a !== 32'h30 || ram_dout !== 8'hAB || mem_data_enable !== 1'b0) begin
            bad++; $display("FAIL sb_bus wr=%b a=%h dout=%h mde=%b want 1/30/ab/0", ram_wr, ram_a, ram_dout, mem_data_enable);
        end
        tick(); // T+2
        total++;
        if (ram_wr !== 1'b0 || mem_data_enable !== 1'b1) begin
            bad++; $display("FAIL sb_done wr=%b mde=%b want 0/1", ram_wr, mem_data_enable);
        end
        mem_enable = 1'b0;
        tick();
        total++;
        if (mem_data_enable !== 1'b0 || ram_wr !== 1'b0) begin
            bad++; $display("FAIL sb_after mde=%b wr=%b want 0/0", mem_data_enable, ram_wr);
        end
    endtask

    task automatic test_sh();
        logic [7:0] exp_d [2];
        exp_d = '{8'hEF, 8'hBE};
        mem_enable = 1'b1; mem_rw = 1'b1; mem_type = 2'd2; mem_addr = 32'h41; mem_wdata = 32'h7777BEEF;
        for (int i = 0; i < 2; i++) begin
            tick();
            total++;
            if (ram_wr !== 1'b1 || ram_a !== 32'h41 + 32'(i) || ram_dout !== exp_d[i]) begin
                bad++; $display("FAIL sh_byte[%0d] wr=%b a=%h dout=%h want 1/%h/%h", i, ram_wr, ram_a, ram_dout, 32'h41 + 32'(i), exp_d[i]);
            end
        end
        tick(); // T+3
        total++;
        if (ram_wr !== 1'b0 || mem_data_enable !== 1'b1) begin
            bad++; $display("FAIL sh_done wr=%b mde=%b want 0/1", ram_wr, mem_data_enable);
        end
        mem_enable = 1'b0;
        tick();
    endtask

    task automatic test_wrap();
        logic [31:0] exp_a [4];
        exp_a = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
        mem_enable = 1'b1; mem_rw = 1'b0; mem_type = 2'd3; mem_addr = 32'hFFFFFFFE;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if (ram_a !== exp_a[i] || ram_wr !== 1'b0) begin
                bad++; $display("FAIL wrap_addr[%0d] ram_a=%h wr=%b want %h/0", i, ram_a, ram_wr, exp_a[i]);
            end
        end
        tick(); tick(); // T+6
        total++;
        if (mem_data_enable !== 1'b1 || mem_data !== 32'h04030201) begin
            bad++; $display("FAIL wrap_done mde=%b mem_data=%h want 1/04030201", mem_data_enable, mem_data);
        end
        mem_enable = 1'b0;
        tick();
    endtask

    // Fetch and LH in the same cycle: LH first, fetch granted in the LH DONE cycle.
    task automatic test_arb();
        if_req = 1'b1; if_addr = 32'h300;
        mem_enable = 1'b1; mem_rw = 1'b0; mem_type = 2'd2; mem_addr = 32'h200;
        tick(); // T+1
        total++;
        if (ram_a !== 32'h200 || icache_busy !== 1'b0) begin
            bad++; $display("FAIL arb_mem_first ram_a=%h busy=%b want 200/0", ram_a, icache_busy);
        end
        tick(); tick(); tick(); // T+4
        total++;
        if (mem_data_enable !== 1'b1 || mem_data !== 32'h0000A55A || icache_busy !== 1'b0) begin
            bad++; $display("FAIL arb_lh_done mde=%b mem_data=%h busy=%b want 1/0000a55a/0", mem_data_enable, mem_data, icache_busy);
        end
        mem_enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick(); // T+5..T+8
            total++;
            if (ram_a !== 32'h300 + 32'(i) || icache_busy !== 1'b1 || mem_data_enable !== 1'b0) begin
                bad++; $display("FAIL arb_fetch_addr[%0d] ram_a=%h busy=%b mde=%b want %h/1/0", i, ram_a, icache_busy, mem_data_enable, 32'h300 + 32'(i));
            end
        end
        tick(); // T+9
        total++;
        if (icache_busy !== 1'b1 || inst_valid !== 1'b0) begin
            bad++; $display("FAIL arb_last_cycle busy=%b iv=%b want 1/0", icache_busy, inst_valid);
        end
        tick(); // T+10
        total++;
        if (inst_valid !== 1'b1 || inst_o !== 32'hEFBEADDE || icache_busy !== 1'b0) begin
            bad++; $display("FAIL arb_fetch_done iv=%b inst_o=%h busy=%b want 1/efbeadde/0", inst_valid, inst_o, icache_busy);
        end
        if_req = 1'b0;
        tick(); // T+11
        total++;
        if (inst_valid !== 1'b0 || ram_a !== 32'h0 || inst_o !== 32'hEFBEADDE) begin
            bad++; $display("FAIL arb_after iv=%b ram_a=%h inst_o=%h want 0/0/efbeadde", inst_valid, ram_a, inst_o);
        end
    endtask

    // MEM request appears during a fetch: fetch is not preempted, LB starts in the fetch DONE cycle.
    task automatic test_fetch_then_mem();
        if_req = 1'b1; if_addr = 32'h300;
        tick(); // T+1
        total++;
        if (ram_a !== 32'h300 || icache_busy !== 1'b1) begin
            bad++; $display("FAIL ftm_start ram_a=%h busy=%b want 300/1", ram_a, icache_busy);
        end
        mem_enable = 1'b1; mem_rw = 1'b0; mem_type = 2'd1; mem_addr = 32'h201;
        for (int i = 1; i < 4; i++) begin
            tick(); // T+2..T+4
            total++;
            if (ram_a !== 32'h300 + 32'(i) || icache_busy !== 1'b1) begin
                bad++; $display("FAIL ftm_no_preempt[%0d] ram_a=%h busy=%b want %h/1", i, ram_a, icache_busy, 32'h300 + 32'(i));
            end
        end
        tick(); // T+5
        total++;
        if (icache_busy !== 1'b1) begin
            bad++; $display("FAIL ftm_busy_last busy=%b want 1", icache_busy);
        end
        tick(); // T+6
        total++;
        if (inst_valid !== 1'b1 || icache_busy !== 1'b0 || inst_o !== 32'hEFBEADDE) begin
            bad++; $display("FAIL ftm_fetch_done iv=%b busy=%b inst_o=%h want 1/0/efbeadde", inst_valid, icache_busy, inst_o);
        end
        if_req = 1'b0;
        tick(); // T+7
        total++;
        if (ram_a !== 32'h201 || ram_wr !== 1'b0 || inst_valid !== 1'b0) begin
            bad++; $display("FAIL ftm_mem_start ram_a=%h wr=%b iv=%b want 201/0/0", ram_a, ram_wr, inst_valid);
        end
        tick(); tick(); // T+9
        total++;
        if (mem_data_enable !== 1'b1 || mem_data !== 32'h000000A5) begin
            bad++; $display("FAIL ftm_lb_done mde=%b mem_data=%h want 1/000000a5", mem_data_enable, mem_data);
        end
        mem_enable = 1'b0;
        tick();
    endtask

    // Reset in the middle of a SW after two bytes have gone out.
    task automatic test_rst_mid();
        mem_enable = 1'b1; mem_rw = 1'b1; mem_type = 2'd3; mem_addr = 32'h50; mem_wdata = 32'hCAFEF00D;
        tick(); // T+1
        total++;
        if (ram_wr !== 1'b1 || ram_a !== 32'h50 || ram_dout !== 8'h0D) begin
            bad++; $display("FAIL rst_sw_b0 wr=%b a=%h dout=%h want 1/50/0d", ram_wr, ram_a, ram_dout);
        end
        tick(); // T+2
        total++;
        if (ram_wr !== 1'b1 || ram_a !== 32'h51 || ram_dout !== 8'hF0) begin
            bad++; $display("FAIL rst_sw_b1 wr=%b a=%h dout=%h want 1/51/f0", ram_wr, ram_a, ram_dout);
        end
        rst = 1'b1;
        tick(); // T+3
        total++;
        if (ram_wr !== 1'b0 || ram_a !== 32'h0 || ram_dout !== 8'h00) begin
            bad++; $display("FAIL rst_bus wr=%b a=%h dout=%h want 0/0/0", ram_wr, ram_a, ram_dout);
        end
        total++;
        if (mem_data !== 32'h0 || inst_o !== 32'h0 || icache_busy !== 1'b0 || mem_data_enable !== 1'b0 || inst_valid !== 1'b0) begin
            bad++; $display("FAIL rst_outs mem_data=%h inst_o=%h busy=%b mde=%b iv=%b want all 0", mem_data, inst_o, icache_busy, mem_data_enable, inst_valid);
        end
        rst = 1'b0;
        mem_enable = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            total++;
            if (mem_data_enable !== 1'b0 || ram_wr !== 1'b0) begin
                bad++; $display("FAIL rst_no_done[%0d] mde=%b wr=%b want 0/0", i, mem_data_enable, ram_wr);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
        ram[10'h100] = 8'h11; ram[10'h101] = 8'h22; ram[10'h102] = 8'h33; ram[10'h103] = 8'h44;
        ram[10'h200] = 8'h5A; ram[10'h201] = 8'hA5;
        ram[10'h300] = 8'hDE; ram[10'h301] = 8'hAD; ram[10'h302] = 8'hBE; ram[10'h303] = 8'hEF;
        ram[10'h3FE] = 8'h01; ram[10'h3FF] = 8'h02; ram[10'h000] = 8'h03; ram[10'h001] = 8'h04;

        rst = 1'b1;
        if_req = 1'b0; if_addr = 32'h0;
        mem_enable = 1'b0; mem_rw = 1'b0; mem_addr = 32'h0; mem_wdata = 32'h0; mem_type = 2'd0;
        #1;

        test_reset();
        test_no_type();
        test_lw();
        test_sb();
        test_sh();
        test_wrap();
        test_arb();
        test_fetch_then_mem();
        test_rst_mid();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
